// File: rtl/uart_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_fifo_pkg
// Description : Shared constants for the buffered UART transmit peripheral:
//               register addresses, parity encoding, transmitter state
//               encoding and the minimum bit divisor.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_fifo_pkg;

    // Register window (4 LSBs of the J1 I/O address)
    localparam logic [3:0] c_addr_data   = 4'h0;
    localparam logic [3:0] c_addr_ctrl   = 4'h2;
    localparam logic [3:0] c_addr_div    = 4'h4;
    localparam logic [3:0] c_addr_status = 4'h6;

    // Parity field encoding; 2'b11 behaves as none
    localparam logic [1:0] c_par_none = 2'b00;
    localparam logic [1:0] c_par_even = 2'b01;
    localparam logic [1:0] c_par_odd  = 2'b10;

    // Smallest divisor the DIV register will hold
    localparam logic [15:0] c_div_min = 16'd2;

    // Transmitter state encoding
    typedef logic [2:0] tx_state_t;
    localparam tx_state_t c_st_idle   = 3'd0;
    localparam tx_state_t c_st_start  = 3'd1;
    localparam tx_state_t c_st_data   = 3'd2;
    localparam tx_state_t c_st_parity = 3'd3;
    localparam tx_state_t c_st_stop   = 3'd4;

    function automatic logic parity_enabled(input logic [1:0] par);
        return (par == c_par_even) || (par == c_par_odd);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_core
// Description : UART frame serialiser. Accepts one byte through a
//               valid/ready handshake, latching divisor and parity with it,
//               then sends start, data (LSB first), optional parity and
//               stop bits on a registered tx line.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_valid       - byte available from the queue
//               o_ready       - core idle; handshake completes on valid&&ready
//               i_data        - byte to send
//               i_div         - clock cycles per bit (>= 2)
//               i_parity      - parity mode
//               o_tx          - serial line, idle high
//               o_busy        - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_core
    import uart_fifo_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic [15:0]          i_div,
    input  logic [1:0]           i_parity,
    output logic                 o_tx,
    output logic                 o_busy
);

    tx_state_t            r_state;
    tx_state_t            w_state_next;
    logic [15:0]          r_div;
    logic [15:0]          r_div_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en;
    logic                 r_par_bit;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 w_tick;
    logic                 w_last_data;
    logic                 w_last_stop;

    assign w_tick      = (r_div_cnt == 16'd0);
    assign w_last_data = (r_bit_cnt == 4'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_cnt == 4'(STOP_BITS - 1));

    assign o_ready = (r_state == c_st_idle);
    assign o_busy  = (r_state != c_st_idle);
    assign o_tx    = r_tx;

    // Next state and the line level for the current state. The line is
    // registered, so tx trails the state by one cycle.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = 1'b1;
        case (r_state)
            c_st_idle: begin
                if (i_valid) w_state_next = c_st_start;
            end
            c_st_start: begin
                w_tx_next = 1'b0;
                if (w_tick) w_state_next = c_st_data;
            end
            c_st_data: begin
                w_tx_next = r_shift[0];
                if (w_tick && w_last_data)
                    w_state_next = r_par_en ? c_st_parity : c_st_stop;
            end
            c_st_parity: begin
                w_tx_next = r_par_bit;
                if (w_tick) w_state_next = c_st_stop;
            end
            c_st_stop: begin
                if (w_tick && w_last_stop) w_state_next = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_tx      <= 1'b1;
            r_div     <= c_div_min;
            r_div_cnt <= 16'd0;
            r_bit_cnt <= 4'd0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tx    <= w_tx_next;
            if (r_state == c_st_idle) begin
                // Divisor and parity are frozen for the whole frame here
                if (i_valid) begin
                    r_shift   <= i_data;
                    r_div     <= i_div;
                    r_div_cnt <= i_div - 16'd1;
                    r_bit_cnt <= 4'd0;
                    r_par_en  <= parity_enabled(i_parity);
                    r_par_bit <= (^i_data) ^ (i_parity == c_par_odd);
                end
            end else if (w_tick) begin
                r_div_cnt <= r_div - 16'd1;
                case (r_state)
                    c_st_data: begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= w_last_data ? 4'd0 : r_bit_cnt + 4'd1;
                    end
                    c_st_stop: r_bit_cnt <= r_bit_cnt + 4'd1;
                    default:   r_bit_cnt <= 4'd0;
                endcase
            end else begin
                r_div_cnt <= r_div_cnt - 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/peripheral_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_uart_fifo
// Description : J1 I/O-mapped UART transmitter with a byte FIFO, runtime
//               baud divisor and selectable parity.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               d_in              - write data from the J1
//               cs, addr, rd, wr  - I/O slot select, address LSBs, strobes
//               d_out             - combinational read data (0 when unmapped)
//               tx                - UART line, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_uart_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int DIV_RESET = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        cs,
    input  logic [3:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] d_out,
    output logic        tx
);

    localparam int             c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_ptr_one = {{c_aw{1'b0}}, 1'b1};

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    // One extra wrap bit on each pointer distinguishes full from empty
    logic [c_aw:0]        r_wr_ptr;
    logic [c_aw:0]        r_rd_ptr;
    logic                 r_en;
    logic [1:0]           r_parity;
    logic [15:0]          r_div;
    logic                 r_ovf;

    logic                 w_empty;
    logic                 w_full;
    logic [c_aw:0]        w_level;
    logic [15:0]          w_level16;
    logic                 w_wr_data;
    logic                 w_wr_ctrl;
    logic                 w_wr_div;
    logic                 w_flush;
    logic                 w_ovf_clr;
    logic                 w_push;
    logic                 w_overflow;
    logic                 w_core_valid;
    logic                 w_core_ready;
    logic                 w_core_busy;
    logic                 w_pop;
    logic                 w_busy;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_level16 = 16'(w_level);

    assign w_wr_data = cs && wr && (addr == c_addr_data);
    assign w_wr_ctrl = cs && wr && (addr == c_addr_ctrl);
    assign w_wr_div  = cs && wr && (addr == c_addr_div);
    assign w_flush   = w_wr_ctrl && d_in[1];
    assign w_ovf_clr = w_wr_ctrl && d_in[2];

    assign w_core_valid = r_en && !w_empty;
    assign w_pop        = w_core_valid && w_core_ready;

    // A pop in the same cycle frees a slot, so a push at FULL still lands.
    // A push coinciding with FLUSH is silently discarded.
    assign w_push     = w_wr_data && !w_flush && (!w_full || w_pop);
    assign w_overflow = w_wr_data && !w_flush && w_full && !w_pop;
    assign w_busy     = w_core_busy || !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= d_in[DATA_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_en     <= 1'b1;
            r_parity <= c_par_none;
            r_div    <= 16'(DIV_RESET);
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;

            if (w_flush)    r_rd_ptr <= r_wr_ptr;
            else if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_one;

            // Setting wins over clearing when both happen together
            if (w_overflow)     r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;

            if (w_wr_ctrl) begin
                r_en     <= d_in[0];
                r_parity <= d_in[4:3];
            end

            if (w_wr_div) r_div <= (d_in < c_div_min) ? c_div_min : d_in;
        end
    end

    always_comb begin
        d_out = 16'h0000;
        if (cs && rd) begin
            case (addr)
                c_addr_ctrl:   d_out = {11'b0, r_parity, 2'b00, r_en};
                c_addr_div:    d_out = r_div;
                c_addr_status: d_out = {w_level16[7:0], 4'b0000, r_ovf,
                                        w_full, w_empty, w_busy};
                default:       d_out = 16'h0000;
            endcase
        end
    end

    uart_tx_core #(
        .DATA_BITS (DATA_BITS),
        .STOP_BITS (STOP_BITS)
    ) u_tx_core (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (w_core_valid),
        .o_ready  (w_core_ready),
        .i_data   (r_mem[r_rd_ptr[c_aw-1:0]]),
        .i_div    (r_div),
        .i_parity (r_parity),
        .o_tx     (tx),
        .o_busy   (w_core_busy)
    );

endmodule
`default_nettype wire

// File: tb/tb_peripheral_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_uart_fifo
// Description : Self-checking bench for peripheral_uart_fifo. A queue-based
//               model tracks FIFO contents and OVF; a line receiver checks
//               every frame cycle by cycle against the expected bit sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_uart_fifo;

    localparam int c_depth = 8;
    localparam int c_stop  = 1;

    localparam logic [3:0] c_a_data   = 4'h0;
    localparam logic [3:0] c_a_ctrl   = 4'h2;
    localparam logic [3:0] c_a_div    = 4'h4;
    localparam logic [3:0] c_a_status = 4'h6;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic        cs;
    logic [3:0]  addr;
    logic        rd;
    logic        wr;
    logic [15:0] d_out;
    logic        tx;

    int n_vec  = 0;
    int n_miss = 0;

    peripheral_uart_fifo #(
        .DEPTH     (c_depth),
        .DATA_BITS (8),
        .STOP_BITS (c_stop),
        .DIV_RESET (434)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ctrl_word(input logic en, input logic flush,
                                              input logic ovf_clr, input logic [1:0] par);
        return {11'b0, par, ovf_clr, flush, en};
    endfunction

    function automatic logic [15:0] status_word(input int level, input logic ovf);
        return {8'(level), 4'b0000, ovf, level == c_depth, level == 0, level != 0};
    endfunction

    // Called on a falling edge; the write is taken at the next rising edge
    task automatic bus_wr(input logic [3:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [15:0] v);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1 v = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    // Wait for a start bit, then check every cycle of the frame.
    // waited = falling edges from call until the first low sample.
    task automatic rx_frame(input int div, input logic [1:0] par, input logic [7:0] b,
                            input string tag, output int waited, output logic [15:0] got);
        logic [15:0] ew;
        int          nb;
        int          good;
        ew = '0; got = '0; nb = 0; good = 0;
        ew[nb] = 1'b0; nb++;
        for (int i = 0; i < 8; i++) begin ew[nb] = b[i]; nb++; end
        if (par == 2'b01)      begin ew[nb] = ^b;    nb++; end
        else if (par == 2'b10) begin ew[nb] = ~(^b); nb++; end
        for (int i = 0; i < c_stop; i++) begin ew[nb] = 1'b1; nb++; end
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < 3000);
        if (tx !== 1'b0) begin
            check_eq({tag, " start timeout"}, 32'(tx), 32'd0);
            return;
        end
        for (int j = 0; j < nb; j++) begin
            for (int k = 0; k < div; k++) begin
                if (!(j == 0 && k == 0)) @(negedge clk);
                if (tx === ew[j]) good++;
                if (k == div / 2) got[j] = tx;
            end
        end
        check_eq({tag, " bits"}, 32'(got), 32'(ew));
        check_eq({tag, " width"}, 32'(good), 32'(nb * div));
    endtask

    task automatic idle_watch(input int cycles, input string tag);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check_eq(tag, 32'(lows), 32'd0);
    endtask

    logic [15:0] rv;
    logic [15:0] got;
    int          w;
    logic [7:0]  mq[$];
    logic        m_ovf;

    initial begin
        rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 4'h0; d_in = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset read-back
        check_eq("reset tx", 32'(tx), 32'd1);
        check_eq("reset d_out", 32'(d_out), 32'd0);
        bus_rd(c_a_status, rv); check_eq("reset status", 32'(rv), 32'h0002);
        bus_rd(c_a_ctrl, rv);   check_eq("reset ctrl", 32'(rv), 32'h0001);
        bus_rd(c_a_div, rv);    check_eq("reset div", 32'(rv), 32'd434);
        bus_rd(4'h8, rv);       check_eq("unmapped read", 32'(rv), 32'd0);
        addr = c_a_status; rd = 1'b1; #1;
        check_eq("read without cs", 32'(d_out), 32'd0);
        rd = 1'b0;
        @(negedge clk);

        // Single byte, no parity, DIV=4
        bus_wr(c_a_div, 16'd4);
        bus_wr(c_a_data, 16'h0055);
        rx_frame(4, 2'b00, 8'h55, "byte55", w, got);
        check_eq("byte55 latency", 32'(w), 32'd2);
        bus_rd(c_a_status, rv); check_eq("byte55 busy after stop", 32'(rv), 32'h0002);

        // Parity: odd then even on 0x07
        bus_wr(c_a_ctrl, ctrl_word(1'b1, 1'b0, 1'b0, 2'b10));
        bus_wr(c_a_data, 16'h0007);
        rx_frame(4, 2'b10, 8'h07, "odd07", w, got);
        check_eq("odd07 parity bit", 32'(got[9]), 32'd0);
        bus_wr(c_a_ctrl, ctrl_word(1'b1, 1'b0, 1'b0, 2'b01));
        bus_wr(c_a_data, 16'h0007);
        rx_frame(4, 2'b01, 8'h07, "even07", w, got);
        check_eq("even07 parity bit", 32'(got[9]), 32'd1);
        bus_rd(c_a_ctrl, rv); check_eq("ctrl readback", 32'(rv), 32'h0009);

        // Overflow with EN=0
        bus_wr(c_a_ctrl, ctrl_word(1'b0, 1'b0, 1'b0, 2'b00));
        for (int i = 0; i <= c_depth; i++) bus_wr(c_a_data, 16'(8'h10 + i));
        bus_rd(c_a_status, rv); check_eq("ovf status", 32'(rv), 32'(status_word(c_depth, 1'b1)));
        bus_wr(c_a_ctrl, ctrl_word(1'b1, 1'b0, 1'b0, 2'b00));
        for (int i = 0; i < c_depth; i++) begin
            rx_frame(4, 2'b00, 8'(8'h10 + i), "ovf drain", w, got);
            check_eq("ovf drain gap", 32'(w), 32'd2);
        end
        idle_watch(40, "ovf dropped byte sent");
        bus_rd(c_a_status, rv); check_eq("ovf after drain", 32'(rv), 32'(status_word(0, 1'b1)));
        bus_wr(c_a_ctrl, ctrl_word(1'b1, 1'b0, 1'b1, 2'b00));
        bus_rd(c_a_status, rv); check_eq("ovf clr", 32'(rv), 32'h0002);

        // Flush mid-frame
        bus_wr(c_a_ctrl, ctrl_word(1'b0, 1'b0, 1'b0, 2'b00));
        bus_wr(c_a_data, 16'h00A1);
        bus_wr(c_a_data, 16'h00B2);
        bus_wr(c_a_data, 16'h00C3);
        bus_wr(c_a_ctrl, ctrl_word(1'b1, 1'b0, 1'b0, 2'b00));
        fork
            rx_frame(4, 2'b00, 8'hA1, "flush first", w, got);
            begin
                repeat (10) @(negedge clk);
                bus_wr(c_a_ctrl, ctrl_word(1'b1, 1'b1, 1'b0, 2'b00));
            end
        join
        idle_watch(100, "flush extra frame");
        bus_rd(c_a_status, rv); check_eq("flush status", 32'(rv), 32'h0002);

        // Divisor clamp and mid-frame change
        bus_wr(c_a_div, 16'd1);
        bus_rd(c_a_div, rv); check_eq("div clamp 1", 32'(rv), 32'd2);
        bus_wr(c_a_div, 16'd0);
        bus_rd(c_a_div, rv); check_eq("div clamp 0", 32'(rv), 32'd2);
        bus_wr(c_a_ctrl, ctrl_word(1'b0, 1'b0, 1'b0, 2'b00));
        bus_wr(c_a_div, 16'd4);
        bus_wr(c_a_data, 16'h003C);
        bus_wr(c_a_data, 16'h00E1);
        bus_wr(c_a_ctrl, ctrl_word(1'b1, 1'b0, 1'b0, 2'b00));
        fork
            rx_frame(4, 2'b00, 8'h3C, "div4 frame", w, got);
            begin
                repeat (6) @(negedge clk);
                bus_wr(c_a_div, 16'd8);
            end
        join
        rx_frame(8, 2'b00, 8'hE1, "div8 frame", w, got);
        check_eq("div8 gap", 32'(w), 32'd2);

        // Reset in the middle of a frame
        bus_wr(c_a_div, 16'd4);
        bus_wr(c_a_data, 16'h00A5);
        bus_wr(c_a_data, 16'h005A);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midframe rst tx", 32'(tx), 32'd1);
        rst = 1'b0;
        bus_rd(c_a_status, rv); check_eq("midframe rst status", 32'(rv), 32'h0002);
        bus_rd(c_a_div, rv);    check_eq("midframe rst div", 32'(rv), 32'd434);
        idle_watch(60, "midframe rst activity");

        // Randomised rounds against the queue model
        m_ovf = 1'b0;
        for (int r = 0; r < 20; r++) begin
            int          dv;
            int          n;
            logic [1:0]  par;
            logic [7:0]  b;
            logic [7:0]  e;
            dv  = $urandom_range(0, 5);
            par = 2'($urandom_range(0, 3));
            n   = $urandom_range(1, c_depth + 2);
            bus_wr(c_a_ctrl, ctrl_word(1'b0, 1'b0, 1'b0, par));
            bus_wr(c_a_div, 16'(dv));
            if (dv < 2) dv = 2;
            bus_rd(c_a_div, rv); check_eq("rand div", 32'(rv), 32'(dv));
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                bus_wr(c_a_data, {8'h00, b});
                if (mq.size() < c_depth) mq.push_back(b);
                else m_ovf = 1'b1;
            end
            if ($urandom_range(0, 1) == 1) begin
                bus_wr(c_a_ctrl, ctrl_word(1'b0, 1'b0, 1'b1, par));
                m_ovf = 1'b0;
            end
            bus_rd(c_a_status, rv);
            check_eq("rand status queued", 32'(rv), 32'(status_word(mq.size(), m_ovf)));
            bus_wr(c_a_ctrl, ctrl_word(1'b1, 1'b0, 1'b0, par));
            while (mq.size() > 0) begin
                e = mq.pop_front();
                rx_frame(dv, (par == 2'b11) ? 2'b00 : par, e, "rand frame", w, got);
                check_eq("rand gap", 32'(w), 32'd2);
            end
            bus_rd(c_a_status, rv);
            check_eq("rand status drained", 32'(rv), 32'(status_word(0, m_ovf)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
